qwi_regarb: RTL and testbench

Shared-bus arbiter and sequencer in front of `qwi_regctrl`: lets NREQ independent register masters (host bridge, video-format manager, debug UART) issue single word reads/writes to the register file through one BRAM-style port. Round-robin grant, one outstanding transaction, fixed-latency read return, tagged response. Optional boot sequencer writes default register values after reset before any requester is served.

---
 rtl/qwi_regarb_pkg.sv | 40 ++++
 rtl/qwi_rr_arbiter.sv | 38 +++
 rtl/qwi_regarb.sv | 234 +++++++++++++++++++++++
 tb/tb_qwi_regarb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/qwi_regarb_pkg.sv
// qwi_regarb_pkg: shared definitions for the register-bus arbiter.
//   - arb_state_e : sequencer states (ST_BOOT only exists when QWI_REGARB_BOOT_EN is defined)
//   - BOOT_CNT, BOOT_ADDR[], BOOT_DATA[] : default register values written after reset
//   - wrap_add()  : modular increment used for round-robin rotation
package qwi_regarb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3
`ifdef QWI_REGARB_BOOT_EN
        , ST_BOOT = 3'd4
`endif
    } arb_state_e;

    // Widths of the boot table entries (register map word address / data).
    localparam int BOOT_AW = 11;
    localparam int BOOT_DW = 32;

    // Word addresses from the shared register map.
    localparam logic [BOOT_AW-1:0] FMT_DEF = 11'd3;

    localparam int BOOT_CNT = 1;
    localparam logic [BOOT_AW-1:0] BOOT_ADDR [BOOT_CNT] = '{FMT_DEF};
    localparam logic [BOOT_DW-1:0] BOOT_DATA [BOOT_CNT] = '{32'd3};

    // (base + off) mod n, for base < n and off <= n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/qwi_rr_arbiter.sv
// qwi_rr_arbiter: combinational round-robin pick.
//   req       in  NREQ  request vector
//   ptr       in  IDW   highest-priority requester this cycle
//   grant     out NREQ  one-hot grant (zero when no request)
//   grant_idx out IDW   index of the granted requester
//   grant_any out 1     at least one request present
module qwi_rr_arbiter
    import qwi_regarb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_any
);

    // Walk the requesters starting at ptr (wrapping) and keep the first hit.
    always_comb begin
        logic [IDW-1:0] cand;
        logic           hit;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        hit       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand      = IDW'(wrap_add(int'(ptr), i, NREQ));
            hit       = !grant_any && req[cand];
            grant     = hit ? (NREQ'(1'b1) << cand) : grant;
            grant_idx = hit ? cand : grant_idx;
            grant_any = grant_any | hit;
        end
    end

endmodule

// File: rtl/qwi_regarb.sv
// qwi_regarb: round-robin arbiter/sequencer giving NREQ register masters
// single-word access to qwi_regctrl through one BRAM-style port.
//   reg_clk/reg_rst            clock, synchronous active-high reset
//   req_valid/ready/wr/be/addr/wdata   per-requester request channel (slice i = requester i)
//   rsp_valid/rsp_id/rsp_rdata registered response pulse, tagged with requester index
//   boot_done                  default-value boot sequence finished
//   reg_ce/we/addr/wrd, reg_rdd  register file port
// Optional feature: define QWI_REGARB_BOOT_EN to write the package boot table
// after reset before any requester is served.
module qwi_regarb
    import qwi_regarb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int AWID   = 11,
    parameter int DWID   = 32,
    parameter int RD_LAT = 1
) (
    input  logic                    reg_clk,
    input  logic                    reg_rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_wr,
    input  logic [NREQ*DWID/8-1:0]  req_be,
    input  logic [NREQ*AWID-1:0]    req_addr,
    input  logic [NREQ*DWID-1:0]    req_wdata,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [DWID-1:0]         rsp_rdata,
    output logic                    boot_done,
    output logic                    reg_ce,
    output logic [DWID/8-1:0]       reg_we,
    output logic [AWID-1:0]         reg_addr,
    output logic [DWID-1:0]         reg_wrd,
    input  logic [DWID-1:0]         reg_rdd
);

    localparam int         IDW      = $clog2(NREQ);
    localparam int         BEW      = DWID / 8;
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);
`ifdef QWI_REGARB_BOOT_EN
    localparam arb_state_e RST_STATE = ST_BOOT;
`else
    localparam arb_state_e RST_STATE = ST_IDLE;
`endif

    arb_state_e      state_r, state_s;
    logic            accept_s;
    logic [NREQ-1:0] arb_grant_s;
    logic [IDW-1:0]  arb_idx_s;
    logic            arb_any_s;
    logic [IDW-1:0]  rr_ptr_r;
    logic [IDW-1:0]  lat_id_r;
    logic            lat_wr_r;
    logic [1:0]      wait_cnt_r;
    logic            rsp_valid_r;
    logic [IDW-1:0]  rsp_id_r;
    logic [DWID-1:0] rsp_rdata_r;
    logic            reg_ce_r;
    logic [BEW-1:0]  reg_we_r;
    logic [AWID-1:0] reg_addr_r;
    logic [DWID-1:0] reg_wrd_r;

    qwi_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_r),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s),
        .grant_any (arb_any_s)
    );

`ifdef QWI_REGARB_BOOT_EN
    logic [7:0]      boot_idx_r;
    logic [2:0]      boot_cnt_r;
    logic            boot_done_r;
    logic            boot_issue_s;
    logic            boot_last_s;
    logic [AWID-1:0] boot_addr_s;
    logic [DWID-1:0] boot_data_s;

    // Each entry occupies slots 0..RD_LAT; the write is launched in slot 0.
    always_comb begin
        boot_addr_s = '0;
        boot_data_s = '0;
        for (int k = 0; k < BOOT_CNT; k++) begin
            boot_addr_s = (boot_idx_r == 8'(k)) ? AWID'(BOOT_ADDR[k]) : boot_addr_s;
            boot_data_s = (boot_idx_r == 8'(k)) ? DWID'(BOOT_DATA[k]) : boot_data_s;
        end
        if (state_r == ST_BOOT) begin
            boot_issue_s = (boot_cnt_r == 3'd0);
            boot_last_s  = (boot_cnt_r == 3'(RD_LAT)) && (boot_idx_r == 8'(BOOT_CNT - 1));
        end else begin
            boot_issue_s = 1'b0;
            boot_last_s  = 1'b0;
        end
    end

    // Boot table walk and completion flag.
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            boot_idx_r  <= 8'd0;
            boot_cnt_r  <= 3'd0;
            boot_done_r <= 1'b0;
        end else if (state_r == ST_BOOT) begin
            if (boot_cnt_r == 3'(RD_LAT)) begin
                boot_cnt_r <= 3'd0;
                boot_idx_r <= boot_idx_r + 8'd1;
            end else begin
                boot_cnt_r <= boot_cnt_r + 3'd1;
            end
            if (boot_last_s) begin
                boot_done_r <= 1'b1;
            end
        end
    end

    assign boot_done = boot_done_r;
`else
    assign boot_done = 1'b1;
`endif

    // Sequencer state register.
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            state_r <= RST_STATE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and accept handshake; ready is suppressed while reset is held.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        req_ready = '0;
        case (state_r)
            ST_IDLE: begin
                if (arb_any_s && !reg_rst) begin
                    req_ready = arb_grant_s;
                    accept_s  = 1'b1;
                    state_s   = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_r == LAT_LAST) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: state_s = ST_IDLE;
`ifdef QWI_REGARB_BOOT_EN
            ST_BOOT: begin
                if (boot_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_BOOT;
                end
            end
`endif
            default: state_s = RST_STATE;
        endcase
    end

    // Request latch, rotation pointer and the register-port drive (valid for one ISSUE cycle).
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            rr_ptr_r   <= '0;
            lat_id_r   <= '0;
            lat_wr_r   <= 1'b0;
            reg_ce_r   <= 1'b0;
            reg_we_r   <= '0;
            reg_addr_r <= '0;
            reg_wrd_r  <= '0;
        end else if (accept_s) begin
            rr_ptr_r   <= IDW'(wrap_add(int'(arb_idx_s), 1, NREQ));
            lat_id_r   <= arb_idx_s;
            lat_wr_r   <= req_wr[arb_idx_s];
            reg_ce_r   <= 1'b1;
            reg_we_r   <= req_wr[arb_idx_s] ? req_be[arb_idx_s*BEW +: BEW] : '0;
            reg_addr_r <= req_addr[arb_idx_s*AWID +: AWID];
            reg_wrd_r  <= req_wdata[arb_idx_s*DWID +: DWID];
        end
`ifdef QWI_REGARB_BOOT_EN
        else if (boot_issue_s) begin
            reg_ce_r   <= 1'b1;
            reg_we_r   <= '1;
            reg_addr_r <= boot_addr_s;
            reg_wrd_r  <= boot_data_s;
        end
`endif
        else begin
            reg_ce_r <= 1'b0;
            reg_we_r <= '0;
        end
    end

    // Read-return latency counter; writes take the same path so latency is uniform.
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            wait_cnt_r <= 2'd0;
        end else if (state_r == ST_WAIT) begin
            wait_cnt_r <= wait_cnt_r + 2'd1;
        end else begin
            wait_cnt_r <= 2'd0;
        end
    end

    // Response register: captured on the last WAIT cycle, id/data hold until the next response.
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
            rsp_rdata_r <= '0;
        end else if ((state_r == ST_WAIT) && (wait_cnt_r == LAT_LAST)) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= lat_id_r;
            rsp_rdata_r <= lat_wr_r ? '0 : reg_rdd;
        end else begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_rdata = rsp_rdata_r;
    assign reg_ce    = reg_ce_r;
    assign reg_we    = reg_we_r;
    assign reg_addr  = reg_addr_r;
    assign reg_wrd   = reg_wrd_r;

endmodule

// File: tb/tb_qwi_regarb.sv
// tb_qwi_regarb: directed self-checking bench for qwi_regarb.
// Two instances share clock/reset: u_dut (RD_LAT=1) and u_dut3 (RD_LAT=3), each
// in front of a small behavioural register-file model. Boot checks are active
// when QWI_REGARB_BOOT_EN is defined.
module tb_qwi_regarb;

    localparam logic [31:0] FW1   = 32'h0102_0304;
    localparam logic [31:0] FW3   = 32'hCAFE_0003;
    localparam logic [31:0] INIT5 = 32'h1122_3344;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]  req_valid, req_ready, req_wr;
    logic [7:0]  req_be;
    logic [21:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid, boot_done, reg_ce;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_rdata, reg_wrd, reg_rdd;
    logic [3:0]  reg_we;
    logic [10:0] reg_addr;

    logic [1:0]  req_valid3, req_ready3;
    logic        rsp_valid3, boot_done3, reg_ce3;
    logic [0:0]  rsp_id3;
    logic [31:0] rsp_rdata3, reg_wrd3, reg_rdd3;
    logic [3:0]  reg_we3;
    logic [10:0] reg_addr3;

    qwi_regarb #(.NREQ(2), .AWID(11), .DWID(32), .RD_LAT(1)) u_dut (
        .reg_clk(clk), .reg_rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_be(req_be),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .boot_done(boot_done),
        .reg_ce(reg_ce), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wrd(reg_wrd), .reg_rdd(reg_rdd)
    );

    qwi_regarb #(.NREQ(2), .AWID(11), .DWID(32), .RD_LAT(3)) u_dut3 (
        .reg_clk(clk), .reg_rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_wr(2'b00), .req_be(8'h00),
        .req_addr(22'd0), .req_wdata(64'd0),
        .rsp_valid(rsp_valid3), .rsp_id(rsp_id3), .rsp_rdata(rsp_rdata3), .boot_done(boot_done3),
        .reg_ce(reg_ce3), .reg_we(reg_we3), .reg_addr(reg_addr3), .reg_wrd(reg_wrd3), .reg_rdd(reg_rdd3)
    );

    // Register file model, 1-cycle read latency; rdd is zero except in the return slot.
    logic [31:0] mem1 [0:15];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) mem1[k] <= 32'h0;
            mem1[0] <= FW1;
            mem1[5] <= INIT5;
            reg_rdd <= 32'h0;
        end else if (reg_ce) begin
            for (int b = 0; b < 4; b++)
                if (reg_we[b]) mem1[reg_addr[3:0]][8*b +: 8] <= reg_wrd[8*b +: 8];
            reg_rdd <= mem1[reg_addr[3:0]];
        end else begin
            reg_rdd <= 32'h0;
        end
    end

    // Register file model, 3-cycle read latency.
    logic [31:0] mem3 [0:15];
    logic [31:0] p0, p1;
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) mem3[k] <= 32'h0;
            mem3[0]  <= FW3;
            p0       <= 32'h0;
            p1       <= 32'h0;
            reg_rdd3 <= 32'h0;
        end else begin
            if (reg_ce3) begin
                for (int b = 0; b < 4; b++)
                    if (reg_we3[b]) mem3[reg_addr3[3:0]][8*b +: 8] <= reg_wrd3[8*b +: 8];
                p0 <= mem3[reg_addr3[3:0]];
            end else begin
                p0 <= 32'h0;
            end
            p1       <= p0;
            reg_rdd3 <= p1;
        end
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on u_dut: accept, issue, wait, response, hold.
    task automatic txn(input string tag, input int id, input logic wr, input logic [3:0] be,
                       input logic [10:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rd);
        tick();
        req_valid = 2'b00;
        req_valid[id] = 1'b1;
        req_wr[id] = wr;
        req_be[id*4 +: 4] = be;
        req_addr[id*11 +: 11] = addr;
        req_wdata[id*32 +: 32] = wdata;
        #1;
        check_vec({tag, "/ready"}, 32'(req_ready), 32'(2'b01 << id));
        tick();
        req_valid = 2'b00;
        #1;
        check_vec({tag, "/ce"}, 32'(reg_ce), 32'd1);
        check_vec({tag, "/addr"}, 32'(reg_addr), 32'(addr));
        check_vec({tag, "/we"}, 32'(reg_we), wr ? 32'(be) : 32'd0);
        if (wr) check_vec({tag, "/wrd"}, reg_wrd, wdata);
        tick(); #1;
        check_vec({tag, "/ce_off"}, 32'(reg_ce), 32'd0);
        check_vec({tag, "/rsp_early"}, 32'(rsp_valid), 32'd0);
        tick(); #1;
        check_vec({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
        check_vec({tag, "/rsp_id"}, 32'(rsp_id), 32'(id));
        check_vec({tag, "/rsp_rdata"}, rsp_rdata, exp_rd);
        tick(); #1;
        check_vec({tag, "/rsp_pulse"}, 32'(rsp_valid), 32'd0);
        check_vec({tag, "/rsp_hold"}, rsp_rdata, exp_rd);
    endtask

`ifdef QWI_REGARB_BOOT_EN
    // Bounded wait for the boot write and boot_done on u_dut.
    task automatic wait_boot();
        int n;
        n = 0;
        while (!reg_ce && n < 20) begin tick(); #1; n++; end
        check_vec("boot/ce", 32'(reg_ce), 32'd1);
        check_vec("boot/we", 32'(reg_we), 32'hF);
        check_vec("boot/addr", 32'(reg_addr), 32'd3);
        check_vec("boot/wrd", reg_wrd, 32'd3);
        n = 0;
        while (!boot_done && n < 20) begin tick(); #1; n++; end
        check_vec("boot/done", 32'(boot_done), 32'd1);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_ready;
        rst = 1'b1;
        req_valid = 2'b11;
        req_wr = 2'b00; req_be = 8'h00; req_addr = 22'd0; req_wdata = 64'd0;
        req_valid3 = 2'b00;
        tick(); tick(); #1;
        // Reset state: everything quiet even with requests pending.
        check_vec("rst/ready", 32'(req_ready), 32'd0);
        check_vec("rst/ce", 32'(reg_ce), 32'd0);
        check_vec("rst/we", 32'(reg_we), 32'd0);
        check_vec("rst/addr", 32'(reg_addr), 32'd0);
        check_vec("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check_vec("rst/rsp_rdata", rsp_rdata, 32'd0);
`ifdef QWI_REGARB_BOOT_EN
        check_vec("rst/boot_done", 32'(boot_done), 32'd0);
`else
        check_vec("rst/boot_done", 32'(boot_done), 32'd1);
`endif
        tick();
        req_valid = 2'b00;
        rst = 1'b0;
`ifdef QWI_REGARB_BOOT_EN
        wait_boot();
`else
        #1;
        check_vec("boot_done", 32'(boot_done), 32'd1);
`endif

        // Both requesters held valid: grants 0,1,0,1 every 4 cycles.
        tick();
        req_valid = 2'b11;
        req_wr = 2'b00;
        req_addr = {11'd0, 11'd5};
        for (int i = 0; i < 16; i++) begin
            #1;
            exp_ready = (i % 4 != 0) ? 2'b00 : (((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
            check_vec("alt/ready", 32'(req_ready), 32'(exp_ready));
            if (i % 4 == 3) begin
                check_vec("alt/rsp_valid", 32'(rsp_valid), 32'd1);
                check_vec("alt/rsp_id", 32'(rsp_id), 32'((i / 4) % 2));
                check_vec("alt/rsp_rdata", rsp_rdata, ((i / 4) % 2 == 1) ? FW1 : INIT5);
            end else begin
                check_vec("alt/rsp_idle", 32'(rsp_valid), 32'd0);
            end
            tick();
        end
        req_valid = 2'b00;

        txn("rd0", 0, 1'b0, 4'h0, 11'd0, 32'h0, FW1);
        txn("wr1", 1, 1'b1, 4'b0011, 11'd5, 32'hAABB_CCDD, 32'h0);
        txn("rb5", 0, 1'b0, 4'h0, 11'd5, 32'h0, 32'h1122_CCDD);
        txn("wr_nobe", 1, 1'b1, 4'b0000, 11'd5, 32'hFFFF_FFFF, 32'h0);
        txn("rb5_nobe", 0, 1'b0, 4'h0, 11'd5, 32'h0, 32'h1122_CCDD);
`ifdef QWI_REGARB_BOOT_EN
        txn("boot_rb", 0, 1'b0, 4'h0, 11'd3, 32'h0, 32'd3);
`endif

        // Reset while waiting for read data: transaction abandoned.
        tick();
        req_valid = 2'b01; req_wr = 2'b00; req_addr = {11'd0, 11'd5};
        tick();
        req_valid = 2'b00;
        tick();
        rst = 1'b1;
        tick(); #1;
        check_vec("midrst/rsp_valid", 32'(rsp_valid), 32'd0);
        check_vec("midrst/ce", 32'(reg_ce), 32'd0);
        check_vec("midrst/addr", 32'(reg_addr), 32'd0);
        check_vec("midrst/rsp_rdata", rsp_rdata, 32'd0);
        tick();
        rst = 1'b0;
`ifdef QWI_REGARB_BOOT_EN
        wait_boot();
`else
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check_vec("midrst/no_rsp", 32'(rsp_valid), 32'd0);
        end
`endif
        txn("post_rst", 1, 1'b0, 4'h0, 11'd0, 32'h0, FW1);

        // RD_LAT=3 instance: response exactly 5 cycles after accept.
        tick();
        req_valid3 = 2'b01;
        #1;
        check_vec("lat3/boot_done", 32'(boot_done3), 32'd1);
        check_vec("lat3/ready", 32'(req_ready3), 32'd1);
        tick();
        req_valid3 = 2'b00;
        #1;
        check_vec("lat3/ce", 32'(reg_ce3), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            tick(); #1;
            check_vec("lat3/rsp_early", 32'(rsp_valid3), 32'd0);
        end
        tick(); #1;
        check_vec("lat3/rsp_valid", 32'(rsp_valid3), 32'd1);
        check_vec("lat3/rsp_id", 32'(rsp_id3), 32'd0);
        check_vec("lat3/rsp_rdata", rsp_rdata3, FW3);
        tick(); #1;
        check_vec("lat3/rsp_pulse", 32'(rsp_valid3), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
